hex_scan_display: RTL and testbench

- Downstream consumer of the nibble-reversal stage; drives a multiplexed common-anode 7-segment bank.
- Accepts a SIZE-bit hex word on a load strobe and buffers it in a shadow register.
- Commits the word to the display only at a frame boundary, so a scan frame never shows digits from two different words.
- Scans one digit per refresh slot with a short anode-off interval at the start of each slot to suppress ghosting.

---
 rtl/hex_disp_pkg.sv | 20 ++
 rtl/hex_to_seg7.sv | 12 +
 rtl/hex_scan_display.sv | 115 +++++++++++
 tb/tb_hex_scan_display.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants for the multiplexed hex 7-segment display.
package hex_disp_pkg;

    // All segments dark (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
    import hex_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_c_o
);

    // Table lookup of the segment pattern.
    assign seg_c_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/hex_scan_display.sv
// Frame-synchronous multiplexed hex display driver for a common-anode bank.
// Words are shadowed on load and committed only at frame wrap so one scan
// frame never mixes digits from two different words.
module hex_scan_display
    import hex_disp_pkg::*;
#(
    parameter int unsigned SIZE        = 16,
    parameter int unsigned DIGITS      = SIZE / 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:SIZE-1]   din,
    input  logic              load,
    input  logic              blank_lz,
    output logic              ack,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int unsigned CNT_W = cnt_width(REFRESH_DIV);
    localparam int unsigned IDX_W = cnt_width(DIGITS);

    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [0:SIZE-1]   shadow_q, shadow_d;
    logic [0:SIZE-1]   disp_q, disp_d;
    logic              pending_q, pending_d;
    logic              ack_q, ack_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic              tick_c;
    logic              commit_c;
    logic [3:0]        nib_c;
    logic              lz_c;
    logic              blank_c;
    logic [6:0]        seg_dec_c;

    // Slot divider, digit index, shadow/commit bookkeeping.
    always_comb begin
        tick_c    = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));
        commit_c  = tick_c && (idx_q == IDX_W'(DIGITS - 1)) && pending_q;
        div_cnt_d = tick_c ? '0 : div_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (tick_c) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        // A load coinciding with a commit is kept for the next frame wrap.
        shadow_d  = load ? din : shadow_q;
        pending_d = load ? 1'b1 : (commit_c ? 1'b0 : pending_q);
        disp_d    = commit_c ? shadow_q : disp_q;
        ack_d     = commit_c;
    end

    // Select the current slot's nibble and its leading-zero status.
    always_comb begin
        logic zero_run;
        nib_c    = 4'h0;
        lz_c     = 1'b0;
        zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_q[int'(SIZE) - 4 - 4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nib_c = disp_q[int'(SIZE) - 4 - 4*i +: 4];
                lz_c  = zero_run && (i != 0);
            end
        end
    end

    hex_to_seg7 u_dec (
        .nib_i   (nib_c),
        .seg_c_o (seg_dec_c)
    );

    // Anode/segment next values: anti-ghost interval and leading-zero blanking.
    always_comb begin
        blank_c = (div_cnt_q < CNT_W'(BLANK_CYC)) || (blank_lz && lz_c);
        an_d    = '1;
        seg_d   = SEG_BLANK;
        if (!blank_c) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = seg_dec_c;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign ack = ack_q;
    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with a 4-cycle slot and 1 blank cycle.
module tb_hex_scan_display;

    localparam int unsigned SIZE   = 16;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned FRAME  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:15] din = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        ack;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ack_cnt = 0;

    hex_scan_display #(
        .SIZE(SIZE), .DIGITS(DIGITS), .REFRESH_DIV(4), .BLANK_CYC(1)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .load(load), .blank_lz(blank_lz),
        .ack(ack), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock; sample 1 time unit after the edge and track ack pulses.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ack === 1'b1) begin
            ack_cnt++;
            chk("ack_phase", 32'(cyc % FRAME), 32'd0);
        end
    endtask

    task automatic to_frame_start();
        while ((cyc % FRAME) != 0) step();
    endtask

    task automatic to_phase(input int ph);
        while ((cyc % FRAME) != ph) step();
    endtask

    // Checks a full frame; slot s expects ans[4s+:4] and segs[7s+:7].
    task automatic frame_check(input string tag, input logic [15:0] ans, input logic [27:0] segs);
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                step();
                if (d == 0) begin
                    chk({tag, "_blank_an"}, 32'(an), 32'hF);
                    chk({tag, "_blank_seg"}, 32'(seg), 32'h7F);
                end else begin
                    chk({tag, "_an"}, 32'(an), 32'(ans[4*s +: 4]));
                    chk({tag, "_seg"}, 32'(seg), 32'(segs[7*s +: 7]));
                end
            end
        end
    endtask

    task automatic load_word(input logic [15:0] w);
        din  = w;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    localparam logic [15:0] AN_ALL  = {4'h7, 4'hB, 4'hD, 4'hE};
    localparam logic [15:0] AN_LZ0  = {4'hF, 4'hF, 4'hF, 4'hE};

    initial begin
        // Reset
        rst = 1'b1;
        step(); step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_ack", 32'(ack), 32'h0);
        rst = 1'b0;
        cyc = 0;
        ack_cnt = 0;

        // Idle frame shows all zeros, no ack
        frame_check("idle", AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40});
        chk("idle_ack_cnt", 32'(ack_cnt), 32'd0);

        // Single mid-frame load of dcba
        to_phase(5);
        load_word(16'hdcba);
        to_frame_start();
        chk("dcba_ack_cnt", 32'(ack_cnt), 32'd1);
        frame_check("dcba", AN_ALL, {7'h21, 7'h46, 7'h03, 7'h08});
        chk("dcba_ack_after", 32'(ack_cnt), 32'd1);

        // Two loads in one frame: latest wins, one ack
        to_phase(3);
        load_word(16'h1234);
        step();
        load_word(16'hfeca);
        to_frame_start();
        chk("feca_ack_cnt", 32'(ack_cnt), 32'd2);
        frame_check("feca", AN_ALL, {7'h0E, 7'h06, 7'h46, 7'h08});

        // Leading-zero blanking
        blank_lz = 1'b1;
        to_phase(4);
        load_word(16'h0005);
        to_frame_start();
        chk("lz5_ack_cnt", 32'(ack_cnt), 32'd3);
        frame_check("lz5", AN_LZ0, {7'h7F, 7'h7F, 7'h7F, 7'h12});
        to_phase(6);
        load_word(16'h0000);
        to_frame_start();
        frame_check("lz0", AN_LZ0, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        chk("lz0_ack_cnt", 32'(ack_cnt), 32'd4);
        blank_lz = 1'b0;

        // Load coinciding with the commit tick
        to_phase(7);
        load_word(16'h4567);
        to_phase(15);
        load_word(16'h89ab);
        chk("coinc_ack_cnt", 32'(ack_cnt), 32'd5);
        frame_check("w4567", AN_ALL, {7'h19, 7'h12, 7'h02, 7'h78});
        chk("coinc_ack_cnt2", 32'(ack_cnt), 32'd6);
        frame_check("w89ab", AN_ALL, {7'h00, 7'h10, 7'h08, 7'h03});
        chk("coinc_ack_cnt3", 32'(ack_cnt), 32'd6);

        // Reset mid-slot with a pending word
        to_phase(5);
        load_word(16'h1111);
        step();
        rst = 1'b1;
        step();
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_seg", 32'(seg), 32'h7F);
        chk("mrst_ack", 32'(ack), 32'h0);
        rst = 1'b0;
        cyc = 0;
        frame_check("mrst_f1", AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40});
        frame_check("mrst_f2", AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40});
        chk("mrst_ack_cnt", 32'(ack_cnt), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
